// File: rtl/alu_control_fsm.sv
// Multi-cycle ALU control unit: fetch/decode/exec/writeback sequencing,
// ALU select and operand muxing, register-file strobes and program counter.
module alu_control_fsm #(
  parameter int REG_RD_CYC = 2,
  parameter int LAT_FWD    = 1,
  parameter int LAT_LOGIC  = 1,
  parameter int LAT_ADD    = 2,
  parameter int LAT_SHIFT  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        zero,
  output logic [2:0]  alu_op,
  output logic        imm_sel,
  output logic        neg_sel,
  output logic [7:0]  shift_imm,
  output logic [7:0]  immediate,
  output logic [2:0]  read_reg1,
  output logic [2:0]  read_reg2,
  output logic [2:0]  write_reg,
  output logic        write_enable,
  output logic [31:0] pc,
  output logic        busy,
  output logic        illegal
);

  typedef enum logic [1:0] {
    FETCH, DECODE, EXEC, WB
  } state_t;

  state_t      state;
  logic [31:0] instr_q;
  logic [3:0]  cnt;
  logic        zero_q;
  logic        wr_q;
  logic        j_q;
  logic        beq_q;
  logic        ill_q;

  logic [2:0] d_alu;
  logic       d_imm;
  logic       d_neg;
  logic [2:0] d_type;
  logic       d_wr;
  logic       d_j;
  logic       d_beq;
  logic       d_ill;
  int         d_lat;

  always_comb begin
    d_alu  = 3'b000;
    d_imm  = 1'b0;
    d_neg  = 1'b0;
    d_type = 3'b000;
    d_wr   = 1'b0;
    d_j    = 1'b0;
    d_beq  = 1'b0;
    d_ill  = 1'b0;
    d_lat  = LAT_FWD;
    case (instr_q[31:24])
      8'h00: begin d_imm = 1'b1; d_wr = 1'b1; end
      8'h01: d_wr = 1'b1;
      8'h02: begin
        d_alu = 3'b001; d_wr = 1'b1; d_lat = LAT_ADD;
      end
      8'h03: begin
        d_alu = 3'b001; d_neg = 1'b1;
        d_wr  = 1'b1;   d_lat = LAT_ADD;
      end
      8'h04: begin
        d_alu = 3'b010; d_wr = 1'b1; d_lat = LAT_LOGIC;
      end
      8'h05: begin
        d_alu = 3'b011; d_wr = 1'b1; d_lat = LAT_LOGIC;
      end
      8'h06: d_j = 1'b1;
      8'h07: begin
        d_alu = 3'b001; d_neg = 1'b1;
        d_beq = 1'b1;   d_lat = LAT_ADD;
      end
      8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C: begin
        d_alu = 3'b100; d_imm = 1'b1;
        d_wr  = 1'b1;   d_lat = LAT_SHIFT;
        case (instr_q[27:24])
          4'h8:    d_type = 3'b000;
          4'h9:    d_type = 3'b001;
          4'hA:    d_type = 3'b011;
          4'hB:    d_type = 3'b101;
          default: d_type = 3'b100;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
  end

  logic [31:0] off_ext;
  logic [31:0] pc_next;
  logic        taken;

  assign off_ext = {{22{instr_q[23]}}, instr_q[23:16], 2'b00};
  assign taken   = j_q | (beq_q & zero_q);
  assign pc_next = pc + 32'd4 + (taken ? off_ext : 32'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= FETCH;
      instr_q      <= '0;
      cnt          <= '0;
      zero_q       <= 1'b0;
      wr_q         <= 1'b0;
      j_q          <= 1'b0;
      beq_q        <= 1'b0;
      ill_q        <= 1'b0;
      instr_ready  <= 1'b1;
      alu_op       <= '0;
      imm_sel      <= 1'b0;
      neg_sel      <= 1'b0;
      shift_imm    <= '0;
      immediate    <= '0;
      read_reg1    <= '0;
      read_reg2    <= '0;
      write_reg    <= '0;
      write_enable <= 1'b0;
      pc           <= '0;
      busy         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (instr_valid) begin
            instr_q     <= instruction;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= DECODE;
          end
        end
        DECODE: begin
          alu_op    <= d_alu;
          imm_sel   <= d_imm;
          neg_sel   <= d_neg;
          shift_imm <= {d_type, 2'b00, instr_q[2:0]};
          immediate <= instr_q[7:0];
          read_reg1 <= instr_q[10:8];
          read_reg2 <= instr_q[2:0];
          write_reg <= instr_q[18:16];
          wr_q      <= d_wr;
          j_q       <= d_j;
          beq_q     <= d_beq;
          ill_q     <= d_ill;
          zero_q    <= 1'b0;
          cnt       <= 4'(REG_RD_CYC + d_lat - 1);
          // Jumps and undefined opcodes never touch the ALU.
          if (d_j || d_ill) begin
            illegal <= d_ill;
            state   <= WB;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            zero_q       <= zero;
            write_enable <= wr_q;
            illegal      <= ill_q;
            state        <= WB;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WB: begin
          pc           <= pc_next;
          write_enable <= 1'b0;
          illegal      <= 1'b0;
          busy         <= 1'b0;
          instr_ready  <= 1'b1;
          state        <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_fsm.sv
// Directed bench for alu_control_fsm: decode fields, EXEC lengths,
// write strobes, branch/jump PC arithmetic, illegal pulse and reset.
module tb_alu_control_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        zero;
  logic [2:0]  alu_op;
  logic        imm_sel;
  logic        neg_sel;
  logic [7:0]  shift_imm;
  logic [7:0]  immediate;
  logic [2:0]  read_reg1;
  logic [2:0]  read_reg2;
  logic [2:0]  write_reg;
  logic        write_enable;
  logic [31:0] pc;
  logic        busy;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  int busy_n, we_n, ill_n;

  always #5 clock = ~clock;

  alu_control_fsm dut (
    .clock(clock), .reset(reset),
    .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero(zero),
    .alu_op(alu_op), .imm_sel(imm_sel), .neg_sel(neg_sel),
    .shift_imm(shift_imm), .immediate(immediate),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_enable(write_enable),
    .pc(pc), .busy(busy), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one instruction and count busy, write and illegal cycles.
  task automatic run(input logic [31:0] ins, input logic z);
    int t;
    t = 0;
    while (!instr_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    instruction = ins;
    instr_valid = 1'b1;
    zero        = z;
    @(posedge clock);
    #1 instr_valid = 1'b0;
    busy_n = 0;
    we_n   = 0;
    ill_n  = 0;
    t      = 0;
    do begin
      @(negedge clock);
      if (busy) busy_n++;
      if (write_enable) we_n++;
      if (illegal) ill_n++;
      t++;
    end while (!instr_ready && t < 50);
    chk("ready_after_op", {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    reset       = 1'b0;
    instruction = '0;
    instr_valid = 1'b0;
    zero        = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_pc", pc, 32'd0);
    chk("rst_outs", {alu_op, imm_sel, neg_sel, shift_imm, immediate,
        read_reg1, read_reg2, write_reg, write_enable, busy, illegal},
        32'd0);
    reset = 1'b1;
    @(negedge clock);

    run(32'h00042A2A, 1'b0);
    chk("loadi_alu", {29'd0, alu_op}, 32'd0);
    chk("loadi_imm_sel", {31'd0, imm_sel}, 32'd1);
    chk("loadi_wreg", {29'd0, write_reg}, 32'd4);
    chk("loadi_immediate", {24'd0, immediate}, 32'h2A);
    chk("loadi_exec", busy_n - 2, 32'd3);
    chk("loadi_we", we_n, 32'd1);
    chk("loadi_pc", pc, 32'h4);

    run(32'h03050102, 1'b0);
    chk("sub_alu", {29'd0, alu_op}, 32'd1);
    chk("sub_neg", {31'd0, neg_sel}, 32'd1);
    chk("sub_rr1", {29'd0, read_reg1}, 32'd1);
    chk("sub_rr2", {29'd0, read_reg2}, 32'd2);
    chk("sub_exec", busy_n - 2, 32'd4);
    chk("sub_we", we_n, 32'd1);
    chk("sub_pc", pc, 32'h8);

    run(32'h06010000, 1'b0);
    chk("j_pc", pc, 32'h10);
    chk("j_exec", busy_n - 2, 32'd0);
    chk("j_we", we_n, 32'd0);

    run(32'h07FE0000, 1'b1);
    chk("beq_t_pc", pc, 32'h0C);
    chk("beq_t_exec", busy_n - 2, 32'd4);
    chk("beq_t_we", we_n, 32'd0);

    run(32'h06000000, 1'b0);
    chk("j0_pc", pc, 32'h10);

    run(32'h07FE0000, 1'b0);
    chk("beq_nt_pc", pc, 32'h14);
    chk("beq_nt_we", we_n, 32'd0);

    run(32'h0A020103, 1'b0);
    chk("sra_alu", {29'd0, alu_op}, 32'd4);
    chk("sra_shift", {24'd0, shift_imm}, 32'h63);
    chk("sra_imm_sel", {31'd0, imm_sel}, 32'd1);
    chk("sra_exec", busy_n - 2, 32'd5);
    chk("sra_we", we_n, 32'd1);
    chk("sra_pc", pc, 32'h18);

    run(32'hFF000000, 1'b0);
    chk("ill_pulse", ill_n, 32'd1);
    chk("ill_we", we_n, 32'd0);
    chk("ill_pc", pc, 32'h1C);

    // add, then reset during its second EXEC cycle
    instruction = 32'h02030102;
    instr_valid = 1'b1;
    @(posedge clock);
    #1 instr_valid = 1'b0;
    we_n = 0;
    repeat (3) begin
      @(negedge clock);
      if (write_enable) we_n++;
    end
    chk("add_busy_exec", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("mid_rst_pc", pc, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) begin
      @(negedge clock);
      if (write_enable) we_n++;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    if (write_enable) we_n++;
    chk("rel_ready", {31'd0, instr_ready}, 32'd1);
    chk("rel_pc", pc, 32'd0);
    chk("rel_outs", {alu_op, imm_sel, neg_sel, shift_imm, immediate,
        read_reg1, read_reg2, write_reg, write_enable, busy, illegal},
        32'd0);
    chk("rst_no_we", we_n, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
